iob_sp_ram_ctrl: RTL and testbench

IOB_SP_RAM_CTRL -- requirements
Module: iob_sp_ram_ctrl

---
 rtl/iob_sp_ram_ctrl.sv | 175 +++++++++++++++++
 tb/tb_iob_sp_ram_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_sp_ram_ctrl.sv
// iob_sp_ram_ctrl: valid/ready request front end for a single-port synchronous RAM,
// with a 2-entry in-order read response buffer and credit-based read admission.
// Optional feature: define IOB_SP_RAM_CTRL_RMW_EN to merge partial byte strobes
// through a read-modify-write sequence; otherwise any nonzero strobe is a full write.
//
// state     | meaning
// ----------+--------------------------------------------------------------------
// ST_IDLE   | accepting requests; a partial write accepted here issues the RMW read
// ST_RMW_WR | merge latched write bytes with ram_dout and write back; req_ready low
module iob_sp_ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam int STRB_W = DATA_W / 8;

    // response buffer and in-flight tracking
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];

    logic              is_write;
    logic              pop;
    logic              credit_ok;
    logic [2:0]        credit_sum;
    logic              accept;
    logic              in_idle;

`ifdef IOB_SP_RAM_CTRL_RMW_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic [DATA_W-1:0] wdata_lat_q, wdata_lat_d;
    logic [STRB_W-1:0] wstrb_lat_q, wstrb_lat_d;
    logic              is_partial;

    assign in_idle    = (state_q == ST_IDLE);
    assign is_partial = is_write & ~(&req_wstrb);
`else
    assign in_idle    = 1'b1;
`endif

    // Admission: reads need a free buffer slot counting in-flight reads and this
    // cycle's pop; writes never return data so they bypass the credit check.
    always_comb begin
        is_write   = |req_wstrb;
        pop        = (cnt_q != 2'd0) & resp_ready;
        credit_sum = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        credit_ok  = (credit_sum < 3'd2);
        req_ready  = rst_n & in_idle & (is_write | credit_ok);
        accept     = req_valid & req_ready;
    end

    // RAM port drive and RMW sequencing; outputs fall to zero whenever nothing is issued.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
        state_d     = state_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        wstrb_lat_d = wstrb_lat_q;
`endif
        if (accept) begin
            ram_en   = 1'b1;
            ram_addr = req_addr;
            if (is_write) begin
                ram_we  = 1'b1;
                ram_din = req_wdata;
            end
`ifdef IOB_SP_RAM_CTRL_RMW_EN
            if (is_partial) begin
                // issue the read of the old word; the write follows next cycle
                ram_we      = 1'b0;
                ram_din     = '0;
                state_d     = ST_RMW_WR;
                addr_lat_d  = req_addr;
                wdata_lat_d = req_wdata;
                wstrb_lat_d = req_wstrb;
            end
`endif
        end
`ifdef IOB_SP_RAM_CTRL_RMW_EN
        else if (state_q == ST_RMW_WR && rst_n) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = addr_lat_q;
            for (int b = 0; b < STRB_W; b++) begin
                ram_din[8*b +: 8] = wstrb_lat_q[b] ? wdata_lat_q[8*b +: 8]
                                                   : ram_dout[8*b +: 8];
            end
            state_d = ST_IDLE;
        end
`endif
    end

    // Response buffer: capture read data the cycle after issue, pop in order.
    always_comb begin
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = accept & ~is_write;
        if (inflight_q) begin
            buf_d[wr_ptr_q] = ram_dout;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    assign resp_valid = (cnt_q != 2'd0);
    assign resp_rdata = buf_q[rd_ptr_q];

    // Buffer and in-flight state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            buf_q      <= '{default: '0};
        end else begin
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
        end
    end

`ifdef IOB_SP_RAM_CTRL_RMW_EN
    // RMW state register and latched partial-write request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_lat_q  <= '0;
            wdata_lat_q <= '0;
            wstrb_lat_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            wstrb_lat_q <= wstrb_lat_d;
        end
    end
`endif

endmodule

// File: tb/tb_iob_sp_ram_ctrl.sv
// tb_iob_sp_ram_ctrl: directed bench for iob_sp_ram_ctrl with a behavioural
// synchronous RAM. Expectations follow IOB_SP_RAM_CTRL_RMW_EN when defined.
module tb_iob_sp_ram_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 14;
    localparam int STRB_W = DATA_W / 8;

`ifdef IOB_SP_RAM_CTRL_RMW_EN
    localparam logic [31:0] EXP_RMW   = 32'h11BB_33DD;
    localparam logic [31:0] EXP_RST   = 32'h1122_3344;
    localparam int          EXP_STALL = 1;
    localparam logic [31:0] EXP_PWE   = 32'd0;
`else
    localparam logic [31:0] EXP_RMW   = 32'hAABB_CCDD;
    localparam logic [31:0] EXP_RST   = 32'hAABB_CCDD;
    localparam int          EXP_STALL = 0;
    localparam logic [31:0] EXP_PWE   = 32'd1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid, resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0]       got_q [$];
    int                n_err = 0;
    int                n_chk = 0;
    int                stall;

    always #5 clk = ~clk;

    iob_sp_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // behavioural single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    // collect popped responses in order
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1)
            got_q.push_back(resp_rdata);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic v, input int a, input logic [31:0] d, input logic [3:0] s);
        req_valid = v;
        req_addr  = ADDR_W'(a);
        req_wdata = d;
        req_wstrb = s;
    endtask

    task automatic wait_resp(input int n, input string tag);
        for (int k = 0; k < 20; k++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        check(tag, 32'(got_q.size()), 32'(n));
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},   32'(req_ready),  32'd0);
        check({tag, "_vld"},   32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, resp_rdata,      32'd0);
        check({tag, "_en"},    32'(ram_en),     32'd0);
        check({tag, "_we"},    32'(ram_we),     32'd0);
        check({tag, "_addr"},  32'(ram_addr),   32'd0);
        check({tag, "_din"},   ram_din,         32'd0);
    endtask

    initial begin
        set_req(1'b0, 0, 32'd0, 4'h0);
        resp_ready = 1'b0;

        // reset with a live write request on the inputs
        repeat (2) @(negedge clk);
        set_req(1'b1, 7, 32'hFFFF_FFFF, 4'hF);
        #2 check_all_zero("reset");
        @(negedge clk);
        set_req(1'b0, 0, 32'd0, 4'h0);
        rst_n = 1'b1;
        #2 check("rel_rdy", 32'(req_ready), 32'd1);

        // preload addresses 0..7
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_req(1'b1, i, pat(i), 4'hF);
            #2 check("pre_rdy", 32'(req_ready), 32'd1);
        end

        // read latency after a write to the same address
        @(negedge clk);
        set_req(1'b1, 5, 32'hDEAD_BEEF, 4'hF);
        #2;
        check("lat_wr_en",   32'(ram_en),   32'd1);
        check("lat_wr_we",   32'(ram_we),   32'd1);
        check("lat_wr_addr", 32'(ram_addr), 32'd5);
        check("lat_wr_din",  ram_din,       32'hDEAD_BEEF);
        @(negedge clk);
        set_req(1'b1, 5, 32'd0, 4'h0);
        resp_ready = 1'b1;
        #2;
        check("lat_rd_en", 32'(ram_en), 32'd1);
        check("lat_rd_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        set_req(1'b0, 0, 32'd0, 4'h0);
        #2 check("lat_n1_vld", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #2;
        check("lat_n2_vld",   32'(resp_valid), 32'd1);
        check("lat_n2_rdata", resp_rdata,      32'hDEAD_BEEF);
        @(negedge clk);
        #2 check("lat_popped", 32'(resp_valid), 32'd0);

        // streaming reads 0..7 (addr 5 now holds DEADBEEF)
        @(negedge clk);
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, i, 32'd0, 4'h0);
            #2 check("stream_rdy", 32'(req_ready), 32'd1);
            @(negedge clk);
        end
        set_req(1'b0, 0, 32'd0, 4'h0);
        wait_resp(8, "stream_cnt");
        for (int i = 0; i < 8; i++)
            check("stream_data", got_at(i), (i == 5) ? 32'hDEAD_BEEF : pat(i));

        // backpressure: two reads fit, third waits, writes still pass
        @(negedge clk);
        got_q.delete();
        resp_ready = 1'b0;
        set_req(1'b1, 1, 32'd0, 4'h0);
        #2 check("bp_rdy0", 32'(req_ready), 32'd1);
        @(negedge clk);
        set_req(1'b1, 2, 32'd0, 4'h0);
        #2 check("bp_rdy1", 32'(req_ready), 32'd1);
        @(negedge clk);
        set_req(1'b1, 3, 32'd0, 4'h0);
        #2 check("bp_rdy2", 32'(req_ready), 32'd0);
        @(negedge clk);
        #2;
        check("bp_hold", 32'(req_ready),  32'd0);
        check("bp_vld",  32'(resp_valid), 32'd1);
        check("bp_data", resp_rdata,      pat(1));
        @(negedge clk);
        set_req(1'b1, 6, pat(6), 4'hF);
        #2;
        check("bp_wr_rdy", 32'(req_ready), 32'd1);
        check("bp_stable", resp_rdata,     pat(1));
        @(negedge clk);
        set_req(1'b1, 3, 32'd0, 4'h0);
        resp_ready = 1'b1;
        #2 check("bp_resume", 32'(req_ready), 32'd1);
        @(negedge clk);
        set_req(1'b0, 0, 32'd0, 4'h0);
        wait_resp(3, "bp_cnt");
        check("bp_d0", got_at(0), pat(1));
        check("bp_d1", got_at(1), pat(2));
        check("bp_d2", got_at(2), pat(3));

        // partial write to addr 3, followed immediately by a read of addr 3
        @(negedge clk);
        set_req(1'b1, 3, 32'h1122_3344, 4'hF);
        #2 check("rmw_init", 32'(req_ready), 32'd1);
        @(negedge clk);
        got_q.delete();
        set_req(1'b1, 3, 32'hAABB_CCDD, 4'h5);
        #2;
        check("rmw_rdy", 32'(req_ready), 32'd1);
        check("rmw_we",  32'(ram_we),    EXP_PWE);
        @(negedge clk);
        set_req(1'b1, 3, 32'd0, 4'h0);
        #2;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
        check("rmw_wr_we",  32'(ram_we), 32'd1);
        check("rmw_wr_din", ram_din,     32'h11BB_33DD);
`endif
        stall = 0;
        for (int k = 0; k < 4; k++) begin
            if (req_ready) break;
            stall++;
            @(negedge clk);
            #2;
        end
        check("rmw_stall", 32'(stall), 32'(EXP_STALL));
        @(negedge clk);
        set_req(1'b0, 0, 32'd0, 4'h0);
        wait_resp(1, "rmw_cnt");
        check("rmw_data", got_at(0), EXP_RMW);

        // reset asserted in the cycle after a partial write, with a read buffered
        @(negedge clk);
        set_req(1'b1, 3, 32'h1122_3344, 4'hF);
        #2;
        @(negedge clk);
        resp_ready = 1'b0;
        got_q.delete();
        set_req(1'b1, 1, 32'd0, 4'h0);
        #2;
        @(negedge clk);
        set_req(1'b1, 3, 32'hAABB_CCDD, 4'h5);
        #2 check("rst_pw_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        set_req(1'b0, 0, 32'd0, 4'h0);
        rst_n = 1'b0;
        #2 check_all_zero("rst_mid");
        @(negedge clk);
        #2 check("rst_hold_en", 32'(ram_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        #2;
        check("rst_rel_rdy", 32'(req_ready),  32'd1);
        check("rst_rel_vld", 32'(resp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2 check("rst_vld_low", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        set_req(1'b1, 3, 32'd0, 4'h0);
        #2 check("rst_rd_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        set_req(1'b0, 0, 32'd0, 4'h0);
        wait_resp(1, "rst_cnt");
        check("rst_data", got_at(0), EXP_RST);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
